cp0_regfile: RTL and testbench

//  Coprocessor-0 register file: holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId, EBase, Config.

---
 rtl/cp0_defs.sv | 77 +++++++
 rtl/cp0_timer.sv | 70 +++++++
 rtl/cp0_regfile.sv | 165 ++++++++++++++++
 tb/tb_cp0_regfile.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_defs.sv
// Shared definitions for the coprocessor-0 register file.
// Holds the register numbers and selects, the Status/Cause bit positions,
// the Status write mask and reset values, and a decoder that maps an
// (addr, sel) pair onto one of the implemented registers.
package cp0_defs;

  // Register numbers and selects
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
  localparam logic [4:0] ADDR_EBASE    = 5'd15;
  localparam logic [4:0] ADDR_CONFIG   = 5'd16;
  localparam logic [2:0] SEL_PRID      = 3'd0;
  localparam logic [2:0] SEL_EBASE     = 3'd1;

  // Status bit positions
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;
  localparam int ST_IM0 = 8;   // IM[7:0] occupies [15:8]
  localparam int ST_BEV = 22;

  // Cause bit positions
  localparam int CA_EXC0 = 2;  // ExcCode occupies [6:2]
  localparam int CA_IP0  = 8;  // IP[7:0] occupies [15:8]
  localparam int CA_IV   = 23;
  localparam int CA_TI   = 30;
  localparam int CA_BD   = 31;

  // Status: IM, BEV, ERL, EXL, IE are writable; everything else reads 0.
  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  // EBase[31:30] are hard-wired to this value.
  localparam logic [1:0]  EBASE_TOP    = 2'b10;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_BADVADDR,
    REG_COUNT,
    REG_COMPARE,
    REG_STATUS,
    REG_CAUSE,
    REG_EPC,
    REG_PRID,
    REG_EBASE,
    REG_CONFIG
  } cp0_reg_e;

  // Anything not listed decodes to REG_NONE: writes drop, reads return 0.
  function automatic cp0_reg_e cp0_decode(input logic [4:0] addr,
                                          input logic [2:0] sel);
    cp0_reg_e r;
    r = REG_NONE;
    if (sel == SEL_PRID) begin
      case (addr)
        ADDR_BADVADDR: r = REG_BADVADDR;
        ADDR_COUNT:    r = REG_COUNT;
        ADDR_COMPARE:  r = REG_COMPARE;
        ADDR_STATUS:   r = REG_STATUS;
        ADDR_CAUSE:    r = REG_CAUSE;
        ADDR_EPC:      r = REG_EPC;
        ADDR_PRID:     r = REG_PRID;
        ADDR_CONFIG:   r = REG_CONFIG;
        default:       r = REG_NONE;
      endcase
    end else if (sel == SEL_EBASE && addr == ADDR_EBASE) begin
      r = REG_EBASE;
    end
    return r;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0.
// Count advances once every COUNT_DIV clocks (COUNT_DIV is 1 or 2) and wraps
// naturally at 2^32. TI is set on the increment edge that makes Count equal
// Compare and stays set until Compare is written.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   i_count_we       load Count from i_wdata and restart the divider phase
//   i_compare_we     load Compare from i_wdata and clear TI
//   i_wdata          write data for either register
//   o_count          current Count
//   o_compare        current Compare
//   o_ti             timer interrupt flag (Cause.TI)
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  // With a divider of 1 the phase never leaves 0 and every cycle is a wrap.
  localparam logic PHASE_LAST = (COUNT_DIV == 2);

  logic        r_phase;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  logic        w_wrap;
  logic        w_inc;
  logic [31:0] w_count_inc;

  assign w_wrap      = (r_phase == PHASE_LAST);
  // A Count write on the same edge suppresses the increment.
  assign w_inc       = w_wrap & ~i_count_we;
  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_phase   <= 1'b0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (i_count_we) begin
        r_count <= i_wdata;
        r_phase <= 1'b0;
      end else begin
        r_phase <= w_wrap ? 1'b0 : ~r_phase;
        if (w_inc) r_count <= w_count_inc;
      end

      if (i_compare_we) r_compare <= i_wdata;

      // Clearing by a Compare write wins over a coincident match.
      if (i_compare_we)                               r_ti <= 1'b0;
      else if (w_inc && (w_count_inc == r_compare))   r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file.
// Holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId, EBase, Config.
// Updated by the exception unit (exception commit, eret) and by MTC0;
// read combinationally by MFC0 (no bypass of a same-cycle write).
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   mtc0_we/addr/sel/wdata          MTC0 write port
//   mfc0_addr/sel -> mfc0_rdata     MFC0 read port
//   exp_we, exp_clean_exl           exception commit / eret commit
//   exp_code, exp_epc, exp_bd       ExcCode, EPC, branch-delay flag
//   exp_badv_we, exp_bad_vaddr      BadVAddr update
//   hw_int                          level interrupt lines
//   epc_out, ebase_out              vectors for the exception unit
//   int_flags, allow_int            pending masked interrupts, global enable
//   special_int_vec, boot_exp_vec   Cause.IV, Status.BEV
//   timer_int                       Cause.TI
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID      = 32'h0000_4220,
  parameter logic [31:0] CONFIG0   = 32'h8000_0000,
  parameter int          COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  input  logic [2:0]  mfc0_sel,
  output logic [31:0] mfc0_rdata,
  input  logic        exp_we,
  input  logic        exp_clean_exl,
  input  logic [4:0]  exp_code,
  input  logic [31:0] exp_epc,
  input  logic        exp_bd,
  input  logic        exp_badv_we,
  input  logic [31:0] exp_bad_vaddr,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc_out,
  output logic [19:0] ebase_out,
  output logic [7:0]  int_flags,
  output logic        allow_int,
  output logic        special_int_vec,
  output logic        boot_exp_vec,
  output logic        timer_int
);

  logic [31:0] r_status;
  logic        r_bd;
  logic        r_iv;
  logic [7:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [17:0] r_ebase;      // EBase[29:12]

  cp0_reg_e    w_wr_reg;
  cp0_reg_e    w_rd_reg;
  logic        w_mtc0_ok;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [31:0] w_cause;
  logic [31:0] w_ebase;
  logic [31:0] w_rdata;

  assign w_wr_reg = cp0_decode(mtc0_addr, mtc0_sel);
  assign w_rd_reg = cp0_decode(mfc0_addr, mfc0_sel);

  // An MTC0 that loses to an exception or eret is dropped entirely,
  // including the Count/Compare side effects inside the timer.
  assign w_mtc0_ok = mtc0_we & ~exp_we & ~exp_clean_exl;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .i_count_we   (w_mtc0_ok && (w_wr_reg == REG_COUNT)),
    .i_compare_we (w_mtc0_ok && (w_wr_reg == REG_COMPARE)),
    .i_wdata      (mtc0_wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_status   <= STATUS_RESET;
      r_bd       <= 1'b0;
      r_iv       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_ebase    <= '0;
    end else begin
      // Hardware IP bits mirror the lines every cycle; IP7 also carries TI.
      r_ip[7:2] <= {hw_int[5] | w_ti, hw_int[4:0]};

      if (exp_we) begin
        // A nested exception (EXL already set) keeps the original EPC/BD.
        if (!r_status[ST_EXL]) begin
          r_epc <= exp_epc;
          r_bd  <= exp_bd;
        end
        r_status[ST_EXL] <= 1'b1;
        r_exc_code       <= exp_code;
        if (exp_badv_we) r_badvaddr <= exp_bad_vaddr;
      end else if (exp_clean_exl) begin
        r_status[ST_EXL] <= 1'b0;
      end else if (mtc0_we) begin
        case (w_wr_reg)
          REG_STATUS: r_status <= (r_status & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK);
          REG_CAUSE: begin
            r_iv      <= mtc0_wdata[CA_IV];
            r_ip[1:0] <= mtc0_wdata[CA_IP0+1:CA_IP0];
          end
          REG_EPC:    r_epc   <= mtc0_wdata;
          REG_EBASE:  r_ebase <= mtc0_wdata[29:12];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_cause                     = '0;
    w_cause[CA_BD]              = r_bd;
    w_cause[CA_TI]              = w_ti;
    w_cause[CA_IV]              = r_iv;
    w_cause[CA_IP0+7:CA_IP0]    = r_ip;
    w_cause[CA_EXC0+4:CA_EXC0]  = r_exc_code;
  end

  assign w_ebase = {EBASE_TOP, r_ebase, 12'h000};

  always_comb begin
    w_rdata = '0;
    case (w_rd_reg)
      REG_BADVADDR: w_rdata = r_badvaddr;
      REG_COUNT:    w_rdata = w_count;
      REG_COMPARE:  w_rdata = w_compare;
      REG_STATUS:   w_rdata = r_status;
      REG_CAUSE:    w_rdata = w_cause;
      REG_EPC:      w_rdata = r_epc;
      REG_PRID:     w_rdata = PRID;
      REG_EBASE:    w_rdata = w_ebase;
      REG_CONFIG:   w_rdata = CONFIG0;
      default:      w_rdata = '0;
    endcase
  end

  assign mfc0_rdata      = w_rdata;
  assign epc_out         = r_epc;
  assign ebase_out       = w_ebase[31:12];
  assign int_flags       = r_ip & r_status[ST_IM0+7:ST_IM0];
  assign allow_int       = ({r_status[ST_ERL], r_status[ST_EXL], r_status[ST_IE]} == 3'b001);
  assign special_int_vec = r_iv;
  assign boot_exp_vec    = r_status[ST_BEV];
  assign timer_int       = w_ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// Testbench for cp0_regfile. Inputs are driven on the falling edge, the DUT
// updates on the rising edge, and outputs are sampled at the next falling
// edge (MFC0 data 1 ns after its address is applied).
module tb_cp0_regfile;

  logic        clk;
  logic        resetn;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [2:0]  mtc0_sel;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [2:0]  mfc0_sel;
  logic [31:0] mfc0_rdata;
  logic        exp_we;
  logic        exp_clean_exl;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exp_bd;
  logic        exp_badv_we;
  logic [31:0] exp_bad_vaddr;
  logic [5:0]  hw_int;
  logic [31:0] epc_out;
  logic [19:0] ebase_out;
  logic [7:0]  int_flags;
  logic        allow_int;
  logic        special_int_vec;
  logic        boot_exp_vec;
  logic        timer_int;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];

  cp0_regfile #(
    .PRID      (32'h0000_4220),
    .CONFIG0   (32'h8000_0000),
    .COUNT_DIV (2)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .mtc0_we         (mtc0_we),
    .mtc0_addr       (mtc0_addr),
    .mtc0_sel        (mtc0_sel),
    .mtc0_wdata      (mtc0_wdata),
    .mfc0_addr       (mfc0_addr),
    .mfc0_sel        (mfc0_sel),
    .mfc0_rdata      (mfc0_rdata),
    .exp_we          (exp_we),
    .exp_clean_exl   (exp_clean_exl),
    .exp_code        (exp_code),
    .exp_epc         (exp_epc),
    .exp_bd          (exp_bd),
    .exp_badv_we     (exp_badv_we),
    .exp_bad_vaddr   (exp_bad_vaddr),
    .hw_int          (hw_int),
    .epc_out         (epc_out),
    .ebase_out       (ebase_out),
    .int_flags       (int_flags),
    .allow_int       (allow_int),
    .special_int_vec (special_int_vec),
    .boot_exp_vec    (boot_exp_vec),
    .timer_int       (timer_int)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic sb_pop_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, got, e);
    end
  endtask

  // ---------------- driver tasks (all start and end on a falling edge) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_sel = s; mtc0_wdata = d;
    @(negedge clk);
    mtc0_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [2:0] s,
                    input logic [31:0] e);
    mfc0_addr = a; mfc0_sel = s;
    sb_push(e);
    #1;
    sb_pop_check(tag, mfc0_rdata);
    @(negedge clk);
  endtask

  task automatic outp(input string tag, input logic [31:0] got, input logic [31:0] e);
    sb_push(e);
    sb_pop_check(tag, got);
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] epc, input logic bd,
                     input logic badv_we, input logic [31:0] vaddr);
    exp_we = 1'b1; exp_code = code; exp_epc = epc; exp_bd = bd;
    exp_badv_we = badv_we; exp_bad_vaddr = vaddr;
    @(negedge clk);
    exp_we = 1'b0; exp_badv_we = 1'b0;
  endtask

  task automatic eret();
    exp_clean_exl = 1'b1;
    @(negedge clk);
    exp_clean_exl = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0; n_fail = 0;
    resetn = 1'b0;
    mtc0_we = 1'b0; mtc0_addr = '0; mtc0_sel = '0; mtc0_wdata = '0;
    mfc0_addr = '0; mfc0_sel = '0;
    exp_we = 1'b0; exp_clean_exl = 1'b0; exp_code = '0; exp_epc = '0; exp_bd = 1'b0;
    exp_badv_we = 1'b0; exp_bad_vaddr = '0; hw_int = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    rd("rst_count", 5'd9, 3'd0, 32'h0);
    outp("rst_ebase_out", {12'h0, ebase_out}, 32'h0008_0000);
    outp("rst_bev",       {31'h0, boot_exp_vec}, 32'h1);
    outp("rst_allow",     {31'h0, allow_int}, 32'h0);
    outp("rst_flags",     {24'h0, int_flags}, 32'h0);
    outp("rst_ti",        {31'h0, timer_int}, 32'h0);
    rd("rst_status", 5'd12, 3'd0, 32'h0040_0000);
    rd("rst_ebase",  5'd15, 3'd1, 32'h8000_0000);
    rd("rst_prid",   5'd15, 3'd0, 32'h0000_4220);
    rd("rst_config", 5'd16, 3'd0, 32'h8000_0000);
    rd("rst_cause",  5'd13, 3'd0, 32'h0);
    rd("rst_epc",    5'd14, 3'd0, 32'h0);
    rd("rst_badv",   5'd8,  3'd0, 32'h0);

    // Read-only and unmapped registers
    mtc0(5'd15, 3'd0, 32'hFFFF_FFFF);
    mtc0(5'd8,  3'd0, 32'h1234_5678);
    mtc0(5'd20, 3'd0, 32'hFFFF_FFFF);
    rd("prid_ro",   5'd15, 3'd0, 32'h0000_4220);
    rd("badv_ro",   5'd8,  3'd0, 32'h0);
    rd("unmapped",  5'd20, 3'd0, 32'h0);
    rd("bad_sel",   5'd12, 3'd1, 32'h0);

    // Timer: Count advances every second clock, TI on reaching Compare
    mtc0(5'd11, 3'd0, 32'd5);
    mtc0(5'd9,  3'd0, 32'd0);
    repeat (8) tick();
    rd("count_4", 5'd9, 3'd0, 32'd4);
    outp("ti_before", {31'h0, timer_int}, 32'h0);
    tick();
    outp("ti_set", {31'h0, timer_int}, 32'h1);
    rd("count_5", 5'd9, 3'd0, 32'd5);
    rd("cause_ti", 5'd13, 3'd0, 32'h4000_8000);
    repeat (4) tick();
    outp("ti_sticky", {31'h0, timer_int}, 32'h1);

    // Compare write: same-cycle read returns the old value, TI clears
    mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_sel = 3'd0; mtc0_wdata = 32'hFFFF_FFFF;
    mfc0_addr = 5'd11; mfc0_sel = 3'd0;
    sb_push(32'd5);
    #1;
    sb_pop_check("cmp_nobypass", mfc0_rdata);
    @(negedge clk);
    mtc0_we = 1'b0;
    outp("ti_clear", {31'h0, timer_int}, 32'h0);
    rd("cmp_new", 5'd11, 3'd0, 32'hFFFF_FFFF);

    // Count wraps through zero
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
    rd("count_max", 5'd9, 3'd0, 32'hFFFF_FFFF);
    tick();
    rd("count_wrap", 5'd9, 3'd0, 32'h0);

    // First exception
    exc(5'h04, 32'hBFC0_0100, 1'b1, 1'b1, 32'h0000_0003);
    rd("exc1_epc",    5'd14, 3'd0, 32'hBFC0_0100);
    rd("exc1_cause",  5'd13, 3'd0, 32'h8000_0010);
    rd("exc1_badv",   5'd8,  3'd0, 32'h0000_0003);
    rd("exc1_status", 5'd12, 3'd0, 32'h0040_0002);
    outp("exc1_allow",  {31'h0, allow_int}, 32'h0);
    outp("exc1_epcout", epc_out, 32'hBFC0_0100);

    // Nested exception keeps EPC/BD; eret beats a same-cycle MTC0
    exc(5'h0A, 32'h0000_1234, 1'b0, 1'b0, 32'h0000_0099);
    rd("exc2_epc",   5'd14, 3'd0, 32'hBFC0_0100);
    rd("exc2_cause", 5'd13, 3'd0, 32'h8000_0028);
    rd("exc2_badv",  5'd8,  3'd0, 32'h0000_0003);
    mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_sel = 3'd0; mtc0_wdata = 32'h0000_DEAD;
    eret();
    mtc0_we = 1'b0;
    rd("eret_status", 5'd12, 3'd0, 32'h0040_0000);
    rd("eret_epc",    5'd14, 3'd0, 32'hBFC0_0100);

    // Exception beats a same-cycle MTC0 Status
    mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_sel = 3'd0; mtc0_wdata = 32'h0000_FF01;
    exc(5'h08, 32'h0000_2000, 1'b0, 1'b0, 32'h0);
    mtc0_we = 1'b0;
    rd("exc3_status", 5'd12, 3'd0, 32'h0040_0002);
    rd("exc3_epc",    5'd14, 3'd0, 32'h0000_2000);
    rd("exc3_cause",  5'd13, 3'd0, 32'h0000_0020);
    eret();

    // Interrupt masking and enable
    mtc0(5'd12, 3'd0, 32'h0000_0401);
    rd("st_0401", 5'd12, 3'd0, 32'h0000_0401);
    outp("bev_clear",  {31'h0, boot_exp_vec}, 32'h0);
    outp("allow_on",   {31'h0, allow_int}, 32'h1);
    hw_int = 6'b000001;
    tick();
    outp("flags_hw0",  {24'h0, int_flags}, 32'h04);
    hw_int = 6'b000000;
    tick();
    outp("flags_drop", {24'h0, int_flags}, 32'h00);

    // Software interrupts and IV
    mtc0(5'd13, 3'd0, 32'h0080_0300);
    rd("cause_sw", 5'd13, 3'd0, 32'h0080_0320);
    outp("iv_on", {31'h0, special_int_vec}, 32'h1);
    mtc0(5'd12, 3'd0, 32'h0000_FF01);
    hw_int = 6'b100000;
    tick();
    outp("flags_sw_hw5", {24'h0, int_flags}, 32'h83);
    hw_int = 6'b000000;
    mtc0(5'd12, 3'd0, 32'h0000_FF05);
    outp("allow_erl", {31'h0, allow_int}, 32'h0);

    // EBase writable field only
    mtc0(5'd15, 3'd1, 32'hFFFF_FFFF);
    rd("ebase_wr", 5'd15, 3'd1, 32'hBFFF_F000);
    outp("ebase_out_wr", {12'h0, ebase_out}, 32'h000B_FFFF);

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
